// File: rtl/button_event_decoder_pkg.sv
// Shared types and constants for the button event decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package button_event_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
        LONG_HELD      = 3'd2,
        WAIT_SECOND    = 3'd3,
        SECOND_PRESSED = 3'd4
    } state_t;

    localparam int DEFAULT_CLK_FREQ_HZ = 50_000_000;
    localparam int CYCLES_PER_MS       = DEFAULT_CLK_FREQ_HZ / 1000;

    // Clock cycles per millisecond for an arbitrary clock frequency.
    function automatic int cycles_per_ms(input int clk_freq_hz);
        return clk_freq_hz / 1000;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_event_decoder_ms_tick.sv
// Millisecond prescaler: one-cycle tick every CYCLES clk cycles.
// Latency: first tick CYCLES cycles after clear/reset.
// Backpressure: none; clear restarts the period synchronously.
module ms_tick_gen
    import button_event_decoder_pkg::*;
#(
    parameter int CYCLES = CYCLES_PER_MS
) (
    input  logic clk,
    input  logic rst_a_p,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    // Free-running modulo-CYCLES counter, restarted by clear.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a debounced button into press/release/short/long/repeat/double-click pulses.
// Latency: edges and held appear on the 3rd clk edge after button_in changes; timed events exact to +/-1 cycle.
// Backpressure: none; every output is a registered one-cycle pulse (held is a level).
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 50_000_000,
    parameter int LONG_PRESS_MS    = 1000,
    parameter int DOUBLE_WINDOW_MS = 300,
    parameter int REPEAT_MS        = 200
) (
    input  logic clk,
    input  logic rst_a_p,
    input  logic button_in,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic double_click
);

    localparam int CYC    = cycles_per_ms(CLK_FREQ_HZ);
    localparam int MS_MAX = max3(LONG_PRESS_MS, DOUBLE_WINDOW_MS, REPEAT_MS);
    localparam int MS_W   = $clog2(MS_MAX + 1);

    // Thresholds are compared against the count before it increments, so an
    // event fires on the same edge the count would reach the full interval.
    localparam logic [MS_W-1:0] LONG_LAST = MS_W'(LONG_PRESS_MS - 1);
    localparam logic [MS_W-1:0] WIN_LAST  = MS_W'(DOUBLE_WINDOW_MS - 1);
    localparam logic [MS_W-1:0] REP_LAST  = MS_W'(REPEAT_MS - 1);
    localparam logic [MS_W-1:0] MS_SAT    = {MS_W{1'b1}};

    logic sync_1, sync_2, sync_3;
    logic press_edge, release_edge;
    logic tick, clear;
    logic [MS_W-1:0] ms_cnt;
    logic long_hit, win_hit, rep_hit;

    state_t state, state_nxt;
    logic   short_nxt, long_nxt, rep_nxt, dbl_nxt;

    // Two-flop synchronizer plus a history flop for edge detection.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= button_in;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    assign press_edge   = sync_2 & ~sync_3;
    assign release_edge = ~sync_2 & sync_3;

    ms_tick_gen #(
        .CYCLES (CYC)
    ) u_ms_tick_gen (
        .clk     (clk),
        .rst_a_p (rst_a_p),
        .clear   (clear),
        .tick    (tick)
    );

    assign long_hit = tick && (ms_cnt >= LONG_LAST);
    assign win_hit  = tick && (ms_cnt >= WIN_LAST);
    assign rep_hit  = tick && (ms_cnt >= REP_LAST);

    // Saturating millisecond counter, restarted whenever the timing base restarts.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            ms_cnt <= '0;
        end else if (clear) begin
            ms_cnt <= '0;
        end else if (tick && (ms_cnt != MS_SAT)) begin
            ms_cnt <= ms_cnt + MS_W'(1);
        end
    end

    // Next-state and event decode; edges take priority over timer expiry.
    always_comb begin
        state_nxt = state;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        rep_nxt   = 1'b0;
        dbl_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (press_edge) state_nxt = PRESSED;
            end
            PRESSED: begin
                if (release_edge) begin
                    state_nxt = WAIT_SECOND;
                end else if (long_hit) begin
                    state_nxt = LONG_HELD;
                    long_nxt  = 1'b1;
                end
            end
            LONG_HELD: begin
                if (release_edge) begin
                    state_nxt = IDLE;
                end else if (rep_hit) begin
                    rep_nxt = 1'b1;
                end
            end
            WAIT_SECOND: begin
                if (press_edge) begin
                    state_nxt = SECOND_PRESSED;
                    dbl_nxt   = 1'b1;
                end else if (win_hit) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end
            end
            SECOND_PRESSED: begin
                if (release_edge) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A repeat restarts its interval exactly like a state change does.
    assign clear = (state_nxt != state) || rep_nxt;

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            state         <= IDLE;
            held          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            double_click  <= 1'b0;
        end else begin
            state         <= state_nxt;
            held          <= sync_2;
            press_pulse   <= press_edge;
            release_pulse <= release_edge;
            short_press   <= short_nxt;
            long_press    <= long_nxt;
            repeat_pulse  <= rep_nxt;
            double_click  <= dbl_nxt;
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder at 10 kHz (10 cycles per ms).
// Stimulus pushes expected (cycle, event mask) entries; a negedge monitor pops and compares.
// Runs a fixed number of cycles per scenario, so it always terminates.
module tb_button_event_decoder;

    localparam logic [5:0] M_PRESS = 6'b100000;
    localparam logic [5:0] M_REL   = 6'b010000;
    localparam logic [5:0] M_SHORT = 6'b001000;
    localparam logic [5:0] M_LONG  = 6'b000100;
    localparam logic [5:0] M_REP   = 6'b000010;
    localparam logic [5:0] M_DBL   = 6'b000001;

    logic clk = 1'b0;
    logic rst_a_p;
    logic button_in;
    logic held, press_pulse, release_pulse, short_press, long_press, repeat_pulse, double_click;

    button_event_decoder #(
        .CLK_FREQ_HZ      (10_000),
        .LONG_PRESS_MS    (5),
        .DOUBLE_WINDOW_MS (3),
        .REPEAT_MS        (2)
    ) dut (
        .clk           (clk),
        .rst_a_p       (rst_a_p),
        .button_in     (button_in),
        .held          (held),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .double_click  (double_click)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [5:0] m;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    wire [5:0] ev = {press_pulse, release_pulse, short_press, long_press, repeat_pulse, double_click};

    // Monitor: every nonzero event vector must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_a_p && ev != 6'b0) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cycle=%0d actual=%b required=none", cyc, ev);
            end else begin
                e = q.pop_front();
                if (e.c != cyc || e.m != ev) begin
                    failures++;
                    $display("FAIL event_match actual cycle=%0d mask=%b required cycle=%0d mask=%b",
                             cyc, ev, e.c, e.m);
                end
            end
        end
    end

    task automatic expect_ev(input int c, input logic [5:0] m);
        exp_t e;
        e.c = c;
        e.m = m;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Advance to just after the posedge that makes cyc == c.
    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    int p;

    initial begin
        rst_a_p   = 1'b1;
        button_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_events", int'(ev), 0);
        chk("reset_held", int'(held), 0);
        rst_a_p = 1'b0;
        go(cyc + 5);

        // Single short press: 20 cycles held.
        p = cyc;
        button_in = 1'b1;
        expect_ev(p + 3, M_PRESS);
        go(p + 4);
        chk("held_after_press", int'(held), 1);
        go(p + 20);
        button_in = 1'b0;
        expect_ev(p + 23, M_REL);
        expect_ev(p + 53, M_SHORT);
        go(p + 70);
        chk("held_after_release", int'(held), 0);

        // Long hold of 120 cycles: long press then repeats, no short press.
        p = cyc;
        button_in = 1'b1;
        expect_ev(p + 3,   M_PRESS);
        expect_ev(p + 53,  M_LONG);
        expect_ev(p + 73,  M_REP);
        expect_ev(p + 93,  M_REP);
        expect_ev(p + 113, M_REP);
        go(p + 120);
        button_in = 1'b0;
        expect_ev(p + 123, M_REL);
        go(p + 170);

        // Double click with a long second press: no long press or repeats.
        p = cyc;
        button_in = 1'b1;
        expect_ev(p + 3, M_PRESS);
        go(p + 10);
        button_in = 1'b0;
        expect_ev(p + 13, M_REL);
        go(p + 25);
        button_in = 1'b1;
        expect_ev(p + 28, M_PRESS | M_DBL);
        go(p + 105);
        button_in = 1'b0;
        expect_ev(p + 108, M_REL);
        go(p + 150);

        // Second press edge exactly on the window-expiry cycle: press wins.
        p = cyc;
        button_in = 1'b1;
        expect_ev(p + 3, M_PRESS);
        go(p + 10);
        button_in = 1'b0;
        expect_ev(p + 13, M_REL);
        go(p + 40);
        button_in = 1'b1;
        expect_ev(p + 43, M_PRESS | M_DBL);
        go(p + 50);
        button_in = 1'b0;
        expect_ev(p + 53, M_REL);
        go(p + 100);

        // Second press one cycle after expiry: short press, then a fresh press.
        p = cyc;
        button_in = 1'b1;
        expect_ev(p + 3, M_PRESS);
        go(p + 10);
        button_in = 1'b0;
        expect_ev(p + 13, M_REL);
        go(p + 41);
        button_in = 1'b1;
        expect_ev(p + 43, M_SHORT);
        expect_ev(p + 44, M_PRESS);
        go(p + 50);
        button_in = 1'b0;
        expect_ev(p + 53, M_REL);
        expect_ev(p + 83, M_SHORT);
        go(p + 110);

        // Release edge coincides with long-press threshold: release wins.
        p = cyc;
        button_in = 1'b1;
        expect_ev(p + 3, M_PRESS);
        go(p + 50);
        button_in = 1'b0;
        expect_ev(p + 53, M_REL);
        expect_ev(p + 83, M_SHORT);
        go(p + 120);

        // Release one cycle after the threshold: long press, no short press.
        p = cyc;
        button_in = 1'b1;
        expect_ev(p + 3, M_PRESS);
        go(p + 51);
        button_in = 1'b0;
        expect_ev(p + 53, M_LONG);
        expect_ev(p + 54, M_REL);
        go(p + 100);

        // Reset during LONG_HELD with the button still held.
        p = cyc;
        button_in = 1'b1;
        expect_ev(p + 3,  M_PRESS);
        expect_ev(p + 53, M_LONG);
        go(p + 60);
        rst_a_p = 1'b1;
        #1;
        chk("midreset_events", int'(ev), 0);
        chk("midreset_held", int'(held), 0);
        go(p + 63);
        rst_a_p = 1'b0;
        p = cyc;
        expect_ev(p + 3,  M_PRESS);
        expect_ev(p + 53, M_LONG);
        go(p + 4);
        chk("held_after_reset", int'(held), 1);
        go(p + 60);
        button_in = 1'b0;
        expect_ev(p + 63, M_REL);
        go(p + 100);

        chk("missing_events", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000: clk frequency; SHALL be a multiple of 1000 and at least 2000.
REQ-002 Parameter LONG_PRESS_MS, default 1000: hold time that qualifies a long press; SHALL be at least 1.
REQ-003 Parameter DOUBLE_WINDOW_MS, default 300: maximum release-to-second-press gap for a double click; SHALL be at least 1.
REQ-004 Parameter REPEAT_MS, default 200: auto-repeat period while long-held; SHALL be at least 1.
REQ-005 Port clk, input, 1: system clock, all logic on its rising edge.
REQ-006 Port rst_a_p, input, 1: reset, asynchronous, active-high.
REQ-007 Port button_in, input, 1: debounced button level, 1 = pressed; asynchronous to clk.
REQ-008 Port held, output, 1: synchronized button level.
REQ-009 Port press_pulse, output, 1: one-cycle pulse on every press edge.
REQ-010 Port release_pulse, output, 1: one-cycle pulse on every release edge.
REQ-011 Port short_press, output, 1: one-cycle pulse for a qualified single short press.
REQ-012 Port long_press, output, 1: one-cycle pulse when a hold reaches LONG_PRESS_MS.
REQ-013 Port repeat_pulse, output, 1: one-cycle pulse every REPEAT_MS while long-held.
REQ-014 Port double_click, output, 1: one-cycle pulse on a qualified second press.

Function
REQ-015 button_in SHALL pass through a 2-flop synchronizer; a third flop holds the previous synchronized value for edge detection.
REQ-016 held, press_pulse and release_pulse SHALL be registered; each asserts on the 3rd rising clk edge after button_in changes.
REQ-017 A millisecond tick SHALL be generated as a synchronous enable (no derived clocks): one-cycle pulse every CLK_FREQ_HZ/1000 cycles.
REQ-018 The tick prescaler and the ms counter SHALL clear synchronously on every state transition, so intervals are exact to +/-1 clk cycle.
REQ-019 The ms counter SHALL be wide enough for max(LONG_PRESS_MS, DOUBLE_WINDOW_MS, REPEAT_MS) and SHALL saturate, never wrap.
REQ-020 FSM states SHALL be IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED.
REQ-021 IDLE: press edge -> PRESSED.
REQ-022 PRESSED: release edge before LONG_PRESS_MS -> WAIT_SECOND.
REQ-023 PRESSED: ms count reaches LONG_PRESS_MS -> pulse long_press, go to LONG_HELD.
REQ-024 LONG_HELD: pulse repeat_pulse each time REPEAT_MS elapses, restarting the count; first repeat occurs REPEAT_MS after long_press.
REQ-025 LONG_HELD: release edge -> IDLE, with no short_press.
REQ-026 WAIT_SECOND: press edge before DOUBLE_WINDOW_MS -> pulse double_click, go to SECOND_PRESSED.
REQ-027 WAIT_SECOND: window expiry -> pulse short_press, go to IDLE.
REQ-028 SECOND_PRESSED: release edge -> IDLE; no long_press or repeat is generated from a second press, regardless of duration.
REQ-029 If window expiry and a press edge occur in the same cycle, the press edge SHALL win (double_click, no short_press).
REQ-030 If long-press threshold and a release edge coincide, the release SHALL win (WAIT_SECOND, no long_press).
REQ-031 Event outputs SHALL be registered and mutually exclusive except that press_pulse and double_click assert together.

Reset
REQ-032 rst_a_p SHALL asynchronously force state IDLE, clear all synchronizer flops, counters and the prescaler, and drive every output to 0.
REQ-033 Reset asserted mid-event SHALL discard the event; after release, a button already held SHALL produce press_pulse as a fresh edge.

Structure
REQ-034 The FSM state enumeration and the constant CYCLES_PER_MS SHALL live in the shared package.
REQ-035 The prescaler SHALL be a sub-module named ms_tick_gen, with ports clk, rst_a_p, clear and tick.

Verification (CLK_FREQ_HZ=10_000, LONG_PRESS_MS=5, DOUBLE_WINDOW_MS=3, REPEAT_MS=2)
REQ-036 Press 20 cycles, release -> press_pulse at +3, release_pulse at +3 after release, short_press exactly 30 cycles after the release_pulse cycle.
REQ-037 Hold 120 cycles -> long_press 50 cycles after press_pulse; repeat_pulse at +20 and +40 after long_press; release gives no short_press.
REQ-038 Press 10 cycles, release 15 cycles, press 80 cycles -> double_click coincident with the 2nd press_pulse; no short_press, long_press or repeat.
REQ-039 Second press edge lands exactly on the window-expiry cycle -> double_click only, no short_press.
REQ-040 rst_a_p pulsed during LONG_HELD with button held -> all outputs 0 immediately; after reset, press_pulse at +3 and long_press 50 cycles later.
